// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the inverse SubBytes datapath.
// Optional feature macro used by inv_subbytes_ctrl: INV_SB_KS_SHARE_EN.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } inv_sb_state_e;

  localparam int unsigned AES_NUM_COLS = 4;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map, then invert in the field
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] a;
    a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

endpackage

// File: rtl/subByte_inv.sv
// Combinational 32-bit inverse word substitution: four inverse S-boxes.
module subByte_inv
  import aes_pkg::*;
(
  input  word_t i_word,
  output word_t o_word
);

  // Byte-wise inverse substitution
  always_comb begin
    o_word = '0;
    for (int b = 0; b < 4; b++) begin
      o_word[8*b +: 8] = inv_sbox(i_word[8*b +: 8]);
    end
  end

endmodule

// File: rtl/inv_subbytes_ctrl.sv
// Sequences inverse SubBytes over a full state through one shared word unit,
// one column per cycle. Define INV_SB_KS_SHARE_EN to let the key schedule
// borrow the word unit (ks_* ports and arbiter).
module inv_subbytes_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NUM_COLS   = AES_NUM_COLS
`ifdef INV_SB_KS_SHARE_EN
  ,
  parameter int unsigned MAX_KS_RUN = 3
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*NUM_COLS-1:0] in_state,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*NUM_COLS-1:0] out_state,
  input  logic                  flush,
  output logic                  busy,
  output word_t                 sbu_in,
  input  word_t                 sbu_out
`ifdef INV_SB_KS_SHARE_EN
  ,
  input  logic                  ks_req,
  input  word_t                 ks_word,
  output logic                  ks_gnt,
  output word_t                 ks_result
`endif
);

  localparam int unsigned ColW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [ColW-1:0] LastCol = ColW'(NUM_COLS - 1);

  inv_sb_state_e          r_st;
  logic [ColW-1:0]        r_col;
  logic [32*NUM_COLS-1:0] r_data;

  word_t                  w_col_word;
  logic [32*NUM_COLS-1:0] w_data_upd;
  logic                   w_col_adv;
  logic                   w_load;

  // Select the current column (column 0 is the MSB word) and form the updated state
  always_comb begin
    w_col_word = '0;
    w_data_upd = r_data;
    for (int c = 0; c < int'(NUM_COLS); c++) begin
      if (r_col == ColW'(c)) begin
        w_col_word                          = r_data[(NUM_COLS-1-c)*32 +: 32];
        w_data_upd[(NUM_COLS-1-c)*32 +: 32] = sbu_out;
      end
    end
  end

  assign busy      = (r_st == BUSY);
  assign out_valid = (r_st == DONE);
  // A flush cycle never completes an input handshake
  assign in_ready  = !flush && ((r_st == IDLE) || ((r_st == DONE) && out_ready));
  assign w_load    = in_ready && in_valid;
  assign out_state = out_valid ? r_data : '0;

`ifdef INV_SB_KS_SHARE_EN
  localparam int unsigned RunW = $clog2(MAX_KS_RUN + 1);

  logic [RunW-1:0] r_run;
  logic            w_ks_gnt;

  // Key schedule wins unless it has already stalled the column MAX_KS_RUN times in a row
  always_comb begin
    w_ks_gnt = ks_req && ((r_st != BUSY) || (r_run < RunW'(MAX_KS_RUN)));
  end

  assign ks_gnt    = w_ks_gnt;
  assign w_col_adv = busy && !w_ks_gnt;
  assign sbu_in    = w_ks_gnt ? ks_word : (busy ? w_col_word : '0);

  // Consecutive-grant counter while BUSY, and the registered key-schedule result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run     <= '0;
      ks_result <= '0;
    end else begin
      if (w_ks_gnt) ks_result <= sbu_out;
      if (flush || !busy || !w_ks_gnt) r_run <= '0;
      else                             r_run <= r_run + RunW'(1);
    end
  end
`else
  assign w_col_adv = busy;
  assign sbu_in    = busy ? w_col_word : '0;
`endif

  // Main FSM: load, substitute one column per un-stalled cycle, hold result until taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st   <= IDLE;
      r_col  <= '0;
      r_data <= '0;
    end else if (flush) begin
      r_st  <= IDLE;
      r_col <= '0;
    end else begin
      unique case (r_st)
        IDLE: begin
          if (w_load) begin
            r_data <= in_state;
            r_col  <= '0;
            r_st   <= BUSY;
          end
        end
        BUSY: begin
          if (w_col_adv) begin
            r_data <= w_data_upd;
            if (r_col == LastCol) begin
              r_col <= '0;
              r_st  <= DONE;
            end else begin
              r_col <= r_col + ColW'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            if (w_load) begin
              r_data <= in_state;
              r_col  <= '0;
              r_st   <= BUSY;
            end else begin
              r_st <= IDLE;
            end
          end
        end
        default: begin
          r_st  <= IDLE;
          r_col <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_subbytes_ctrl.sv
// Self-checking bench for inv_subbytes_ctrl with the word unit alongside.
// Key-sharing checks are compiled in when INV_SB_KS_SHARE_EN is defined.
module tb_inv_subbytes_ctrl;
  import aes_pkg::*;

  localparam int unsigned NC = AES_NUM_COLS;
  localparam int unsigned W  = 32 * NC;

  logic         clk       = 1'b0;
  logic         reset_n   = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic         flush     = 1'b0;
  logic [W-1:0] in_state  = '0;
  logic [W-1:0] out_state;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [31:0]  sbu_in;
  logic [31:0]  sbu_out;
`ifdef INV_SB_KS_SHARE_EN
  logic         ks_req  = 1'b0;
  logic [31:0]  ks_word = '0;
  logic         ks_gnt;
  logic [31:0]  ks_result;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] ref_inv [256];

  always #5 clk = ~clk;

  inv_subbytes_ctrl u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .flush     (flush),
    .busy      (busy),
    .sbu_in    (sbu_in),
    .sbu_out   (sbu_out)
`ifdef INV_SB_KS_SHARE_EN
    ,
    .ks_req    (ks_req),
    .ks_word   (ks_word),
    .ks_gnt    (ks_gnt),
    .ks_result (ks_result)
`endif
  );

  subByte_inv u_sbu (
    .i_word (sbu_in),
    .o_word (sbu_out)
  );

  // Reference model: forward S-box from its definition, inverted as a table
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    return 8'((x << k) | (x >> (8 - k)));
  endfunction

  task automatic build_model();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      ref_inv[s] = 8'(x);
    end
  endtask

  function automatic logic [W-1:0] model_state(input logic [W-1:0] s);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W / 8); i++) r[8*i +: 8] = ref_inv[s[8*i +: 8]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Wait for out_valid with a cycle budget; returns cycles elapsed
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  task automatic run_txn(input logic [W-1:0] din, input logic [W-1:0] exp,
                         input string name, input int stall);
    int cyc;
    in_valid = 1'b1;
    in_state = din;
    step();
    in_valid = 1'b0;
    chk({name, " busy"}, 128'(busy), 128'(1));
    wait_done(cyc);
    chk({name, " latency"}, 128'(cyc), 128'(NC));
    for (int s = 0; s < stall; s++) begin
      step();
      chk({name, " hold valid"}, 128'(out_valid), 128'(1));
    end
    chk({name, " data"}, 128'(out_state), 128'(exp));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] dout;
    string        name;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int cyc;
    logic [W-1:0] d;

    vecs[0] = '{din: {16{8'h63}}, dout: {16{8'h00}}, name: "all63"};
    vecs[1] = '{din: {16{8'h00}}, dout: {16{8'h52}}, name: "all00"};
    vecs[2] = '{din: {16{8'h7c}}, dout: {16{8'h01}}, name: "all7c"};
    vecs[3] = '{din: {32'h63636363, 32'h7c7c7c7c, 32'h00000000, 32'h7c7c7c7c},
                dout: {32'h00000000, 32'h01010101, 32'h52525252, 32'h01010101},
                name: "mixed"};

    build_model();

    // Reset values
    #13;
    chk("rst in_ready", 128'(in_ready), 128'(1));
    chk("rst out_valid", 128'(out_valid), 128'(0));
    chk("rst busy", 128'(busy), 128'(0));
    chk("rst out_state", 128'(out_state), 128'(0));
    chk("rst sbu_in", 128'(sbu_in), 128'(0));
`ifdef INV_SB_KS_SHARE_EN
    chk("rst ks_gnt", 128'(ks_gnt), 128'(0));
    chk("rst ks_result", 128'(ks_result), 128'(0));
`endif
    reset_n = 1'b1;
    step();

    // Fixed vectors, no stalls
    for (int i = 0; i < 4; i++) run_txn(vecs[i].din, vecs[i].dout, vecs[i].name, 0);

    // Back-to-back: new state accepted in the DONE cycle, no idle cycle
    in_valid = 1'b1;
    in_state = {16{8'h00}};
    step();
    in_valid = 1'b0;
    wait_done(cyc);
    chk("b2b first latency", 128'(cyc), 128'(NC));
    chk("b2b first data", 128'(out_state), 128'({16{8'h52}}));
    in_valid  = 1'b1;
    in_state  = {16{8'h7c}};
    out_ready = 1'b1;
    #1;
    chk("b2b in_ready", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    chk("b2b no bubble", 128'(busy), 128'(1));
    chk("b2b valid drop", 128'(out_valid), 128'(0));
    wait_done(cyc);
    chk("b2b second latency", 128'(cyc), 128'(NC));
    chk("b2b second data", 128'(out_state), 128'({16{8'h01}}));
    step();
    out_ready = 1'b0;
    chk("b2b idle after", 128'(busy | out_valid), 128'(0));

    // Output held for 5 cycles of backpressure
    in_valid = 1'b1;
    in_state = {16{8'h7c}};
    step();
    in_state = {16{8'h63}};
    wait_done(cyc);
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("hold in_ready", 128'(in_ready), 128'(0));
      chk("hold out_valid", 128'(out_valid), 128'(1));
      chk("hold out_state", 128'(out_state), 128'({16{8'h01}}));
      chk("hold sbu_in", 128'(sbu_in), 128'(0));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("hold release in_ready", 128'(in_ready), 128'(1));
    step();
    out_ready = 1'b0;
    chk("hold release idle", 128'(out_valid), 128'(0));

    // Flush in the second BUSY cycle
    in_valid = 1'b1;
    in_state = {16{8'h00}};
    step();
    in_valid = 1'b0;
    step();
    flush    = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("flush in_ready", 128'(in_ready), 128'(0));
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush busy", 128'(busy), 128'(0));
    chk("flush out_valid", 128'(out_valid), 128'(0));
    chk("flush in_ready idle", 128'(in_ready), 128'(1));
    cyc = 0;
    for (int s = 0; s < 6; s++) begin
      step();
      if (out_valid || busy) cyc++;
    end
    chk("flush no output", 128'(cyc), 128'(0));
    run_txn({16{8'h63}}, {16{8'h00}}, "post flush", 0);

`ifdef INV_SB_KS_SHARE_EN
    // Key schedule holding the unit: 3 grants then one column, repeating
    ks_req  = 1'b1;
    ks_word = 32'h63636363;
    #1;
    chk("ks idle grant", 128'(ks_gnt), 128'(1));
    in_valid = 1'b1;
    in_state = {16{8'h7c}};
    step();
    in_valid = 1'b0;
    chk("ks result", 128'(ks_result), 128'(0));
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      chk("ks grant pattern", 128'(ks_gnt), 128'((cyc % 4) != 3));
      step();
      cyc++;
    end
    chk("ks latency", 128'(cyc), 128'(NC * 4));
    chk("ks data", 128'(out_state), 128'({16{8'h01}}));
    chk("ks result held", 128'(ks_result), 128'(0));
    ks_req    = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`endif

    // Async reset in the middle of BUSY
    in_valid = 1'b1;
    in_state = {16{8'h7c}};
    step();
    in_valid = 1'b0;
    step();
    #1;
    reset_n = 1'b0;
    #1;
    chk("areset busy", 128'(busy), 128'(0));
    chk("areset out_valid", 128'(out_valid), 128'(0));
    chk("areset in_ready", 128'(in_ready), 128'(1));
    chk("areset out_state", 128'(out_state), 128'(0));
    chk("areset sbu_in", 128'(sbu_in), 128'(0));
    cyc = 0;
    for (int s = 0; s < 6; s++) begin
      step();
      if (out_valid) cyc++;
    end
    chk("areset no partial", 128'(cyc), 128'(0));
    reset_n = 1'b1;
    step();
    run_txn({16{8'h00}}, {16{8'h52}}, "post reset", 0);

    // Random states against the model, random backpressure
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < int'(NC); k++) d[32*k +: 32] = $urandom;
      run_txn(d, model_state(d), "random", int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
